shared_bus_receiver: RTL and testbench

- Receiving end of the multiplexed 8-bit tri-state bus: samples the common bus_data on each clock when exactly one source (A or B) is driving it.
- Tags each captured word with its source and buffers it in a small FIFO drained by a valid/ready consumer.
- Tracks bus conflicts (both enables high) with a recovery state machine, plus saturating conflict and overflow counters for debug.

---
 rtl/bus_pkg.sv | 16 +
 rtl/shared_bus_receiver_if.sv | 29 ++
 rtl/bus_rx_fifo.sv | 45 ++++
 rtl/shared_bus_receiver.sv | 92 +++++++++
 tb/tb_shared_bus_receiver.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the multiplexed tri-state bus: FSM encoding, source tags
// and the default bus width used by both the driver and the receiver.
package bus_pkg;

    localparam int BUS_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RECV     = 2'd1,
        ST_CONFLICT = 2'd2
    } bus_state_e;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/shared_bus_receiver_if.sv
// Bus-side, consumer-side and debug signals of the shared bus receiver.
// The slave modport is the receiver's view; master is the environment's view.
interface shared_bus_receiver_if #(
    parameter int DATA_W = bus_pkg::BUS_DATA_W,
    parameter int CNT_W  = 8
);
    logic [DATA_W-1:0] bus_data;
    logic              en_a;
    logic              en_b;
    logic              rd_ready;
    logic              clear_stats;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_src;
    logic              full;
    logic [1:0]        bus_state;
    logic [CNT_W-1:0]  conflict_cnt;
    logic [CNT_W-1:0]  overflow_cnt;

    modport slave (
        input  bus_data, en_a, en_b, rd_ready, clear_stats,
        output rd_valid, rd_data, rd_src, full, bus_state, conflict_cnt, overflow_cnt
    );

    modport master (
        output bus_data, en_a, en_b, rd_ready, clear_stats,
        input  rd_valid, rd_data, rd_src, full, bus_state, conflict_cnt, overflow_cnt
    );
endinterface

// File: rtl/bus_rx_fifo.sv
// Synchronous FIFO with extra-MSB pointers; head word is read combinationally.
// Storage is reset so the head output is never X, even while empty.
module bus_rx_fifo #(
    parameter int W     = 9,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wdata;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

endmodule

// File: rtl/shared_bus_receiver.sv
// Receiver for the shared A/B tri-state bus: captures single-driver cycles into a
// source-tagged FIFO and tracks bus conflicts and dropped words.
module shared_bus_receiver
    import bus_pkg::*;
#(
    parameter int DATA_W = BUS_DATA_W,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    shared_bus_receiver_if.slave  bus
);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    bus_state_e        state, state_nxt;
    logic              capture;
    logic              pop;
    logic              push_ok;
    logic              drop;
    logic              conflict_entry;
    logic              fifo_full;
    logic              fifo_empty;
    logic [DATA_W:0]   head;
    logic [CNT_W-1:0]  conflict_cnt;
    logic [CNT_W-1:0]  overflow_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Once in CONFLICT, only a fully idle bus lets the receiver start over.
    always_comb begin
        state_nxt = ST_IDLE;
        case (state)
            ST_IDLE, ST_RECV: begin
                if (bus.en_a && bus.en_b)      state_nxt = ST_CONFLICT;
                else if (bus.en_a ^ bus.en_b)  state_nxt = ST_RECV;
                else                           state_nxt = ST_IDLE;
            end
            ST_CONFLICT: begin
                if (!bus.en_a && !bus.en_b)    state_nxt = ST_IDLE;
                else                           state_nxt = ST_CONFLICT;
            end
            default:                           state_nxt = ST_IDLE;
        endcase
    end

    assign conflict_entry = (state_nxt == ST_CONFLICT) && (state != ST_CONFLICT);
    assign capture        = (bus.en_a ^ bus.en_b) && (state != ST_CONFLICT);
    assign pop            = !fifo_empty && bus.rd_ready;
    assign push_ok        = capture && (!fifo_full || pop);
    assign drop           = capture && fifo_full && !pop;

    bus_rx_fifo #(
        .W     (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_ok),
        .pop   (pop),
        .wdata ({bus.en_b, bus.bus_data}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            overflow_cnt <= '0;
        end else if (bus.clear_stats) begin
            conflict_cnt <= '0;
            overflow_cnt <= '0;
        end else begin
            if (conflict_entry && conflict_cnt != CNT_MAX) conflict_cnt <= conflict_cnt + CNT_ONE;
            if (drop && overflow_cnt != CNT_MAX)           overflow_cnt <= overflow_cnt + CNT_ONE;
        end
    end

    assign bus.rd_valid     = !fifo_empty;
    assign bus.rd_data      = head[DATA_W-1:0];
    assign bus.rd_src       = head[DATA_W];
    assign bus.full         = fifo_full;
    assign bus.bus_state    = state;
    assign bus.conflict_cnt = conflict_cnt;
    assign bus.overflow_cnt = overflow_cnt;

endmodule

// File: tb/tb_shared_bus_receiver.sv
// Directed bench for shared_bus_receiver: expected words go into a scoreboard queue,
// a negedge monitor pops and compares them whenever the DUT hands one off.
module tb_shared_bus_receiver;
    import bus_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    shared_bus_receiver_if #(.DATA_W(8), .CNT_W(8)) dut_if ();

    shared_bus_receiver #(.DATA_W(8), .DEPTH(4), .CNT_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (dut_if.slave)
    );

    int errors = 0;
    int checks = 0;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer-side monitor: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && dut_if.rd_valid === 1'b1 && dut_if.rd_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected none", {dut_if.rd_src, dut_if.rd_data});
            end else begin
                chk("pop_word", {23'd0, dut_if.rd_src, dut_if.rd_data}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic cycle(input logic a, input logic b, input logic [7:0] d,
                         input logic rdy, input logic clr);
        dut_if.en_a        = a;
        dut_if.en_b        = b;
        dut_if.bus_data    = d;
        dut_if.rd_ready    = rdy;
        dut_if.clear_stats = clr;
        @(posedge clk);
        #1;
    endtask

    initial begin
        dut_if.en_a = 0; dut_if.en_b = 0; dut_if.bus_data = 'z;
        dut_if.rd_ready = 0; dut_if.clear_stats = 0;
        #12;
        chk("rst_rd_valid", dut_if.rd_valid, 0);
        chk("rst_full",     dut_if.full, 0);
        chk("rst_rd_data",  {dut_if.rd_src, dut_if.rd_data}, 0);
        chk("rst_state",    dut_if.bus_state, ST_IDLE);
        chk("rst_counters", {dut_if.conflict_cnt, dut_if.overflow_cnt}, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // Single A word, then a B word, then drain
        exp_q.push_back({SRC_A, 8'hAA});
        cycle(1, 0, 8'hAA, 0, 0);
        chk("a_rd_valid", dut_if.rd_valid, 1);
        chk("a_rd_data",  dut_if.rd_data, 8'hAA);
        chk("a_rd_src",   dut_if.rd_src, SRC_A);
        chk("a_state",    dut_if.bus_state, ST_RECV);
        exp_q.push_back({SRC_B, 8'hCC});
        cycle(0, 1, 8'hCC, 0, 0);
        cycle(0, 0, 8'h00, 1, 0);
        cycle(0, 0, 8'h00, 1, 0);
        chk("drain_rd_valid", dut_if.rd_valid, 0);
        chk("drain_state",    dut_if.bus_state, ST_IDLE);

        // Conflict episode: nothing captured until the bus is idle again
        cycle(1, 1, 8'h11, 0, 0);
        cycle(1, 1, 8'h22, 0, 0);
        chk("cf_state", dut_if.bus_state, ST_CONFLICT);
        cycle(1, 0, 8'h33, 0, 0);
        cycle(1, 0, 8'h44, 0, 0);
        chk("cf_hold_state", dut_if.bus_state, ST_CONFLICT);
        chk("cf_no_capture", dut_if.rd_valid, 0);
        chk("cf_cnt",        dut_if.conflict_cnt, 1);
        cycle(0, 0, 8'h00, 0, 0);
        chk("cf_exit_state", dut_if.bus_state, ST_IDLE);
        exp_q.push_back({SRC_B, 8'h55});
        cycle(0, 1, 8'h55, 0, 0);
        chk("cf_resume_valid", dut_if.rd_valid, 1);
        cycle(0, 0, 8'h00, 1, 0);

        // Simultaneous push and pop on empty: push stored
        exp_q.push_back({SRC_A, 8'h77});
        cycle(1, 0, 8'h77, 1, 0);
        chk("empty_pp_valid", dut_if.rd_valid, 1);
        cycle(0, 0, 8'h00, 1, 0);

        // Overflow: six pushes into four entries
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) exp_q.push_back({SRC_A, 8'(i)});
            cycle(1, 0, 8'(i), 0, 0);
        end
        chk("ovf_full", dut_if.full, 1);
        chk("ovf_cnt",  dut_if.overflow_cnt, 2);
        chk("ovf_head", dut_if.rd_data, 8'h01);

        // Push and pop on full: no drop, stays full
        exp_q.push_back({SRC_A, 8'h07});
        cycle(1, 0, 8'h07, 1, 0);
        chk("fpp_full", dut_if.full, 1);
        chk("fpp_cnt",  dut_if.overflow_cnt, 2);
        for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1, 0);
        chk("fpp_drained", dut_if.rd_valid, 0);
        chk("sb_empty", exp_q.size(), 0);

        // Reset mid-operation with 3 words queued and the bus still driven
        cycle(1, 0, 8'h11, 0, 0);
        cycle(1, 0, 8'h12, 0, 0);
        cycle(1, 0, 8'h13, 0, 0);
        chk("pre_rst_valid", dut_if.rd_valid, 1);
        #2 rst_n = 0;
        #1;
        chk("mid_rst_valid",    dut_if.rd_valid, 0);
        chk("mid_rst_full",     dut_if.full, 0);
        chk("mid_rst_counters", {dut_if.conflict_cnt, dut_if.overflow_cnt}, 0);
        chk("mid_rst_state",    dut_if.bus_state, ST_IDLE);
        @(posedge clk); #1;
        chk("rst_held_state", dut_if.bus_state, ST_IDLE);
        chk("rst_held_valid", dut_if.rd_valid, 0);
        exp_q.delete();
        dut_if.en_a = 0;
        rst_n = 1;
        @(posedge clk); #1;

        // Saturate conflict_cnt, then clear it while another conflict starts
        for (int i = 0; i < 256; i++) begin
            cycle(1, 1, 8'h00, 0, 0);
            cycle(0, 0, 8'h00, 0, 0);
        end
        chk("sat_cnt", dut_if.conflict_cnt, 255);
        cycle(1, 1, 8'h00, 0, 1);
        chk("clr_priority", dut_if.conflict_cnt, 0);
        cycle(0, 0, 8'h00, 0, 0);
        cycle(1, 1, 8'h00, 0, 0);
        chk("post_clr_cnt", dut_if.conflict_cnt, 1);
        cycle(0, 0, 8'h00, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
